// File: rtl/player_pixel_compositor_if.sv
// Pixel/ROM/blink signal bundle around the player pixel compositor.
//   master : the surrounding logic (sprite address generator, background,
//            sprite ROM, VGA colour mapper, game logic)
//   slave  : the compositor itself
// Signals:
//   playerOn, spriteAddress, bgRGB  current pixel coverage, ROM word address, background
//   vsync_pulse, hit                per-frame pulse, damage pulse
//   romData / romAddr               sprite ROM data in / registered ROM address out
//   pixelRGB, playerPixel           composited pixel, opaque-player-pixel flag
//   invincible                      blink window active
//   paletteSel                      only with PLAYER_PALETTE_SWAP_EN: 1 selects PAL1
interface player_pixel_compositor_if;
`ifdef PLAYER_PALETTE_SWAP_EN
   logic        paletteSel;
`endif
   logic        playerOn;
   logic [20:0] spriteAddress;
   logic [23:0] bgRGB;
   logic        vsync_pulse;
   logic        hit;
   logic [3:0]  romData;
   logic [20:0] romAddr;
   logic [23:0] pixelRGB;
   logic        playerPixel;
   logic        invincible;

   modport master (
`ifdef PLAYER_PALETTE_SWAP_EN
      output paletteSel,
`endif
      output playerOn, spriteAddress, bgRGB, vsync_pulse, hit, romData,
      input  romAddr, pixelRGB, playerPixel, invincible
   );

   modport slave (
`ifdef PLAYER_PALETTE_SWAP_EN
      input  paletteSel,
`endif
      input  playerOn, spriteAddress, bgRGB, vsync_pulse, hit, romData,
      output romAddr, pixelRGB, playerPixel, invincible
   );
endinterface

// File: rtl/player_pixel_compositor.sv
// Player pixel compositor: fetches the sprite palette index from ROM, maps it
// through the palette, keys index 0 as transparent over the background and
// applies the post-hit invincibility blink. Latency ROM_LATENCY+2, 1 pixel/cycle.
// Ports:
//   frame_Clk  pixel clock
//   Reset      synchronous, active-high
//   bus        player_pixel_compositor_if.slave (see interface file)
// Optional feature: define PLAYER_PALETTE_SWAP_EN to add bus.paletteSel, which
// travels with the pixel and selects PAL1 instead of PAL0.
//
// state  | meaning
// IDLE   | normal play, player always visible
// INVULN | post-hit window, frame_cnt frames left, visible blinks
module player_pixel_compositor #(
   parameter int ROM_LATENCY  = 2,
   parameter int BLINK_FRAMES = 120,
   parameter int BLINK_PERIOD = 8
) (
   input  logic frame_Clk,
   input  logic Reset,
   player_pixel_compositor_if.slave bus
);
   localparam int         DEPTH       = ROM_LATENCY + 1;
   localparam int         VIS_BIT     = $clog2(BLINK_PERIOD);
   localparam logic [7:0] FRAMES_INIT = 8'(BLINK_FRAMES);
   localparam logic       INIT_VIS    = ~FRAMES_INIT[VIS_BIT];

   localparam logic [23:0] PAL0 [0:15] = '{
      24'h000000, 24'h101010, 24'hF8D8B0, 24'hE03020,
      24'h2040C0, 24'hF0C020, 24'h803010, 24'hFFFFFF,
      24'h30A030, 24'hC08060, 24'h602080, 24'hA0A0A0,
      24'h404040, 24'hFF8000, 24'h00C0C0, 24'hE0E0E0
   };
`ifdef PLAYER_PALETTE_SWAP_EN
   localparam logic [23:0] PAL1 [0:15] = '{
      24'h000000, 24'h101010, 24'hF8D8B0, 24'h20A0E0,
      24'hE04020, 24'h20E0F0, 24'h103080, 24'hFFFFFF,
      24'hA030A0, 24'hC08060, 24'h208060, 24'hA0A0A0,
      24'h404040, 24'h00FF80, 24'hC0C000, 24'hE0E0E0
   };
   logic [DEPTH-1:0] sel_sr;
`endif

   typedef enum logic {IDLE, INVULN} state_t;

   state_t                 state;
   logic [7:0]             frame_cnt;
   logic [7:0]             cnt_dec;
   logic                   visible;
   logic [DEPTH-1:0]       on_sr;
   logic [DEPTH-1:0][23:0] bg_sr;
   logic [23:0]            pal_rgb;
   logic                   draw;

   assign cnt_dec = frame_cnt - 8'd1;

   always_comb begin
      pal_rgb = PAL0[bus.romData];
`ifdef PLAYER_PALETTE_SWAP_EN
      if (sel_sr[DEPTH-1]) pal_rgb = PAL1[bus.romData];
`endif
      draw = on_sr[DEPTH-1] && (bus.romData != 4'd0) && visible;
   end

   // Pixel pipeline: coverage and background ride alongside the ROM access
   // so they meet romData at the output register.
   always_ff @(posedge frame_Clk) begin
      if (Reset) begin
         bus.romAddr     <= 21'd0;
         bus.pixelRGB    <= 24'd0;
         bus.playerPixel <= 1'b0;
         on_sr           <= '0;
         bg_sr           <= '0;
`ifdef PLAYER_PALETTE_SWAP_EN
         sel_sr          <= '0;
`endif
      end else begin
         bus.romAddr     <= bus.playerOn ? bus.spriteAddress : 21'd0;
         on_sr           <= {on_sr[DEPTH-2:0], bus.playerOn};
         bg_sr           <= {bg_sr[DEPTH-2:0], bus.bgRGB};
`ifdef PLAYER_PALETTE_SWAP_EN
         sel_sr          <= {sel_sr[DEPTH-2:0], bus.paletteSel};
`endif
         bus.pixelRGB    <= draw ? pal_rgb : bg_sr[DEPTH-1];
         bus.playerPixel <= draw;
      end
   end

   // Blink FSM. visible only moves on vsync_pulse so a frame never tears.
   always_ff @(posedge frame_Clk) begin
      if (Reset) begin
         state          <= IDLE;
         frame_cnt      <= 8'd0;
         visible        <= 1'b1;
         bus.invincible <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.hit) begin
                  state          <= INVULN;
                  frame_cnt      <= FRAMES_INIT;
                  bus.invincible <= 1'b1;
                  if (bus.vsync_pulse) visible <= INIT_VIS;
               end else if (bus.vsync_pulse) begin
                  visible <= 1'b1;
               end
            end
            INVULN: begin
               if (bus.vsync_pulse) begin
                  if (frame_cnt > 8'd1) begin
                     frame_cnt <= cnt_dec;
                     visible   <= ~cnt_dec[VIS_BIT];
                  end else begin
                     state          <= IDLE;
                     frame_cnt      <= 8'd0;
                     visible        <= 1'b1;
                     bus.invincible <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_player_pixel_compositor.sv
module tb_player_pixel_compositor;
   logic frame_Clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   player_pixel_compositor_if bus ();

   player_pixel_compositor dut (
      .frame_Clk (frame_Clk),
      .Reset     (Reset),
      .bus       (bus)
   );

   always #5 frame_Clk = ~frame_Clk;

   // Sprite ROM model, two-cycle read latency.
   logic [3:0] rom_q0, rom_q1;
   function automatic logic [3:0] rom_f(input logic [20:0] a);
      return (a == 21'd21680) ? 4'd5 : a[3:0];
   endfunction
   always @(posedge frame_Clk) begin
      rom_q0 <= rom_f(bus.romAddr);
      rom_q1 <= rom_q0;
   end
   assign bus.romData = rom_q1;

   localparam logic [23:0] P0_5 = 24'hF0C020;
   localparam logic [23:0] BLUE = 24'h0000FF;

   typedef struct {
      logic        on;
      logic [20:0] addr;
      logic [23:0] bg;
      logic [20:0] exp_addr;
      logic [23:0] exp_rgb;
      logic        exp_pp;
   } vec_t;
   vec_t vecs [8];

   task automatic step();
      @(posedge frame_Clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
      end
   endtask

   task automatic set_pix(input logic on, input logic [20:0] addr, input logic [23:0] bg);
      bus.playerOn      = on;
      bus.spriteAddress = addr;
      bus.bgRGB         = bg;
   endtask

   task automatic pulse_vsync();
      bus.vsync_pulse = 1'b1;
      step();
      bus.vsync_pulse = 1'b0;
   endtask

   initial begin
      vecs[0] = '{1'b1, 21'd21680, 24'h123456, 21'd21680, 24'hF0C020, 1'b1};
      vecs[1] = '{1'b1, 21'h10,    24'h0000FF, 21'h10,    24'h0000FF, 1'b0};
      vecs[2] = '{1'b0, 21'd21680, 24'hABCDEF, 21'd0,     24'hABCDEF, 1'b0};
      vecs[3] = '{1'b1, 21'h23,    24'h000000, 21'h23,    24'hE03020, 1'b1};
      vecs[4] = '{1'b1, 21'h7F,    24'h111111, 21'h7F,    24'hE0E0E0, 1'b1};
      vecs[5] = '{1'b1, 21'h01,    24'h222222, 21'h01,    24'h101010, 1'b1};
      vecs[6] = '{1'b0, 21'h00,    24'h00FF00, 21'd0,     24'h00FF00, 1'b0};
      vecs[7] = '{1'b1, 21'h04,    24'h333333, 21'h04,    24'h2040C0, 1'b1};

      Reset = 1'b1;
      set_pix(1'b0, 21'd0, 24'd0);
      bus.vsync_pulse = 1'b0;
      bus.hit         = 1'b0;
`ifdef PLAYER_PALETTE_SWAP_EN
      bus.paletteSel  = 1'b0;
`endif
      repeat (3) step();
      chk("rst_romAddr", 0, 32'(bus.romAddr), 32'd0);
      chk("rst_pixel", 0, 32'(bus.pixelRGB), 32'd0);
      chk("rst_pp", 0, 32'(bus.playerPixel), 32'd0);
      chk("rst_inv", 0, 32'(bus.invincible), 32'd0);
      Reset = 1'b0;

      // Streaming vectors: romAddr one cycle later, pixel four cycles later.
      for (int k = 0; k < 12; k++) begin
         if (k >= 1 && k <= 8) chk("vec_romAddr", k - 1, 32'(bus.romAddr), 32'(vecs[k-1].exp_addr));
         if (k >= 4) begin
            chk("vec_pixel", k - 4, 32'(bus.pixelRGB), 32'(vecs[k-4].exp_rgb));
            chk("vec_pp", k - 4, 32'(bus.playerPixel), 32'(vecs[k-4].exp_pp));
         end
         if (k < 8) set_pix(vecs[k].on, vecs[k].addr, vecs[k].bg);
         else       set_pix(1'b0, 21'd0, 24'd0);
         step();
      end

      // Latency boundary: the pixel is not out after 3 cycles, it is after 4.
      set_pix(1'b1, 21'd21680, 24'h0000FF);
      step();
      set_pix(1'b0, 21'd0, 24'h000000);
      step(); step();
      chk("lat3_pixel", 0, 32'(bus.pixelRGB), 32'd0);
      step();
      chk("lat4_pixel", 0, 32'(bus.pixelRGB), 32'(P0_5));

      // Blink window: hit, then 120 frames; second hit at frame 50 is ignored.
      set_pix(1'b1, 21'd21680, BLUE);
      repeat (6) step();
      chk("pre_hit_pixel", 0, 32'(bus.pixelRGB), 32'(P0_5));
      bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      chk("hit_inv", 0, 32'(bus.invincible), 32'd1);
      step();
      chk("hit_vis_hold", 0, 32'(bus.pixelRGB), 32'(P0_5));
      for (int k = 1; k <= 120; k++) begin
         logic [23:0] exp_rgb;
         bus.hit = (k == 50);
         pulse_vsync();
         bus.hit = 1'b0;
         chk("blink_inv", k, 32'(bus.invincible), 32'(k < 120));
         step();
         exp_rgb = (k == 120 || ((k - 1) / 8) % 2 == 0) ? P0_5 : BLUE;
         chk("blink_pixel", k, 32'(bus.pixelRGB), 32'(exp_rgb));
      end

      // hit together with vsync in IDLE: full count, no decrement, first frame dark.
      bus.hit = 1'b1;
      pulse_vsync();
      bus.hit = 1'b0;
      chk("hv_inv", 0, 32'(bus.invincible), 32'd1);
      step();
      chk("hv_pixel", 0, 32'(bus.pixelRGB), 32'(BLUE));
      for (int k = 1; k <= 120; k++) begin
         pulse_vsync();
         chk("hv_count_inv", k, 32'(bus.invincible), 32'(k < 120));
      end

      // Reset at frame 30 of the window with pixels in flight.
      bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
      for (int k = 0; k < 30; k++) begin
         pulse_vsync();
         step();
      end
      chk("f30_inv", 0, 32'(bus.invincible), 32'd1);
      Reset = 1'b1;
      step();
      chk("mid_rst_inv", 0, 32'(bus.invincible), 32'd0);
      chk("mid_rst_pixel", 0, 32'(bus.pixelRGB), 32'd0);
      chk("mid_rst_pp", 0, 32'(bus.playerPixel), 32'd0);
      chk("mid_rst_romAddr", 0, 32'(bus.romAddr), 32'd0);
      Reset = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         step();
         chk("flush_pixel", c, 32'(bus.pixelRGB), 32'd0);
         chk("flush_pp", c, 32'(bus.playerPixel), 32'd0);
      end
      step();
      chk("post_rst_pixel", 0, 32'(bus.pixelRGB), 32'(P0_5));
      pulse_vsync();
      chk("post_rst_inv", 0, 32'(bus.invincible), 32'd0);

`ifdef PLAYER_PALETTE_SWAP_EN
      // paletteSel travels with its pixel: one PAL1 pixel, then PAL0 again.
      bus.paletteSel = 1'b1;
      step();
      bus.paletteSel = 1'b0;
      step(); step();
      step();
      chk("swap_pal1", 0, 32'(bus.pixelRGB), 32'h20E0F0);
      step();
      chk("swap_pal0", 0, 32'(bus.pixelRGB), 32'(P0_5));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
